pcie_rx_os_detector: RTL

Receive-side ordered-set detector for the PCIe serdes agent. It consumes the 8b/10b-decoded symbol stream, one symbol per cycle, after symbol lock. It classifies Gen1/Gen2 ordered sets (TS1, TS2, SKP, FTS, EIOS, EIEOS) and produces per-type event pulses, saturating counters and captured TS fields. Those outputs drive the debug/observation interface's received-count and detection fields.

---
 rtl/pcie_rx_os_detector.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pcie_rx_os_detector.sv
// Receive-side ordered-set detector: classifies TS1/TS2/SKP/FTS/EIOS(/EIEOS) from the decoded symbol stream.
// Define PCIE_OS_DET_EIEOS_EN to enable EIEOS detection; otherwise EIE after COM is malformed.
module pcie_rx_os_detector #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             rx_k,
  input  logic             rx_lock,
  input  logic             cnt_clr,
  output logic             ts1_det,
  output logic             ts2_det,
  output logic             skp_det,
  output logic             fts_det,
  output logic             eios_det,
  output logic             eieos_det,
  output logic             os_err,
  output logic [7:0]       ts_link_num,
  output logic [7:0]       ts_lane_num,
  output logic [7:0]       ts_n_fts,
  output logic [7:0]       ts_rate,
  output logic [7:0]       ts_ctrl,
  output logic             ts_link_pad,
  output logic             ts_lane_pad,
  output logic [7:0]       ts_consec,
  output logic [2:0]       skp_len,
  output logic [CNT_W-1:0] ts1_cnt,
  output logic [CNT_W-1:0] ts2_cnt,
  output logic [CNT_W-1:0] skp_cnt,
  output logic [CNT_W-1:0] fts_cnt,
  output logic [CNT_W-1:0] eios_cnt,
  output logic [CNT_W-1:0] eieos_cnt
);

  localparam logic [7:0] K_COM = 8'hBC, K_SKP = 8'h1C, K_FTS = 8'h3C, K_IDL = 8'h7C;
  localparam logic [7:0] K_EIE = 8'hFC, K_PAD = 8'hF7, D10_2 = 8'h4A, D5_2 = 8'h45;
`ifdef PCIE_OS_DET_EIEOS_EN
  localparam bit EIEOS_EN = 1'b1;
`else
  localparam bit EIEOS_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_TS_BODY, S_SKP, S_FTS, S_EIOS, S_EIEOS} state_t;

  state_t     state_reg, state_next;
  logic [3:0] idx_reg, idx_next;          // number of the next expected symbol
  logic [2:0] skp_run_reg, skp_run_next;
  logic [7:0] buf_reg [5];                // TS symbols 1..5 of the TS in flight
  logic [1:0] pad_reg;
  logic [7:0] type_reg, prev_type_reg;
  logic       prev_valid_reg;
  logic [5:0] det_next, det_reg;          // ts1, ts2, skp, fts, eios, eieos
  logic       err_next, ts_done, ts_sym_ok, ts_same;
  logic [2:0] skp_len_val;

  logic accept, is_d, is_com, is_skp, is_fts, is_idl, is_eie, is_pad;
  assign accept = rx_valid && rx_lock;
  assign is_d   = !rx_k;
  assign is_com = rx_k && (rx_data == K_COM);
  assign is_skp = rx_k && (rx_data == K_SKP);
  assign is_fts = rx_k && (rx_data == K_FTS);
  assign is_idl = rx_k && (rx_data == K_IDL);
  assign is_eie = rx_k && (rx_data == K_EIE);
  assign is_pad = rx_k && (rx_data == K_PAD);

  always_comb begin
    ts_sym_ok = 1'b0;
    if (idx_reg == 4'd2)      ts_sym_ok = is_d || is_pad;
    else if (idx_reg <= 4'd5) ts_sym_ok = is_d;
    else if (idx_reg == 4'd6) ts_sym_ok = is_d && (rx_data == D10_2 || rx_data == D5_2);
    else                      ts_sym_ok = is_d && (rx_data == type_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      idx_reg     <= 4'd0;
      skp_run_reg <= 3'd0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      skp_run_reg <= skp_run_next;
    end
  end

  // COM always restarts a header; whether that is an error is decided in the output logic.
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    skp_run_next = skp_run_reg;
    if (!rx_lock) begin
      state_next = S_IDLE;
    end else if (rx_valid) begin
      if (is_com) begin
        state_next = S_HDR;
      end else begin
        unique case (state_reg)
          S_IDLE: state_next = S_IDLE;
          S_HDR: begin
            idx_next = 4'd2;
            if (is_skp) begin
              state_next   = S_SKP;
              skp_run_next = 3'd1;
            end else if (is_fts)             state_next = S_FTS;
            else if (is_idl)                 state_next = S_EIOS;
            else if (is_eie && EIEOS_EN)     state_next = S_EIEOS;
            else if (is_d || is_pad)         state_next = S_TS_BODY;
            else                             state_next = S_IDLE;
          end
          S_TS_BODY: begin
            if (!ts_sym_ok || idx_reg == 4'd15) state_next = S_IDLE;
            else idx_next = idx_reg + 4'd1;
          end
          S_SKP: begin
            if (is_skp && skp_run_reg != 3'd4) skp_run_next = skp_run_reg + 3'd1;
            else state_next = S_IDLE;
          end
          S_FTS, S_EIOS: begin
            if (!(state_reg == S_FTS ? is_fts : is_idl) || idx_reg == 4'd3) state_next = S_IDLE;
            else idx_next = idx_reg + 4'd1;
          end
          S_EIEOS: begin
            if (idx_reg == 4'd15 || !is_eie) state_next = S_IDLE;
            else idx_next = idx_reg + 4'd1;
          end
          default: state_next = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    det_next    = 6'd0;
    err_next    = 1'b0;
    ts_done     = 1'b0;
    skp_len_val = is_skp ? 3'd5 : skp_run_reg;
    if (accept) begin
      if (is_com) begin
        if (state_reg == S_SKP)       det_next[2] = 1'b1;
        else if (state_reg != S_IDLE) err_next = 1'b1;
      end else begin
        unique case (state_reg)
          S_IDLE: ;
          S_HDR:
            err_next = !(is_skp || is_fts || is_idl || is_d || is_pad || (is_eie && EIEOS_EN));
          S_TS_BODY: begin
            if (!ts_sym_ok) err_next = 1'b1;
            else if (idx_reg == 4'd15) begin
              ts_done = 1'b1;
              if (type_reg == D10_2) det_next[0] = 1'b1;
              else                   det_next[1] = 1'b1;
            end
          end
          S_SKP: det_next[2] = !is_skp || (skp_run_reg == 3'd4);
          S_FTS: begin
            if (!is_fts) err_next = 1'b1;
            else if (idx_reg == 4'd3) det_next[3] = 1'b1;
          end
          S_EIOS: begin
            if (!is_idl) err_next = 1'b1;
            else if (idx_reg == 4'd3) det_next[4] = 1'b1;
          end
          S_EIEOS: begin
            if (idx_reg == 4'd15) begin
              if (is_d && rx_data == D10_2) det_next[5] = 1'b1;
              else err_next = 1'b1;
            end else if (!is_eie) err_next = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Capture buffer for the TS in flight; only published when the TS completes cleanly.
  always_ff @(posedge clk) begin
    if (accept && state_reg == S_HDR) begin
      buf_reg[0] <= rx_data;
      pad_reg[0] <= is_pad;
    end else if (accept && state_reg == S_TS_BODY) begin
      for (int i = 1; i < 5; i++)
        if (idx_reg == 4'(i + 1)) buf_reg[i] <= rx_data;
      if (idx_reg == 4'd2) pad_reg[1] <= is_pad;
      if (idx_reg == 4'd6) type_reg <= rx_data;
    end
  end

  assign ts_same = prev_valid_reg && (prev_type_reg == type_reg) &&
                   (ts_link_num == buf_reg[0]) && (ts_lane_num == buf_reg[1]) &&
                   (ts_n_fts == buf_reg[2]) && (ts_rate == buf_reg[3]) && (ts_ctrl == buf_reg[4]) &&
                   (ts_link_pad == pad_reg[0]) && (ts_lane_pad == pad_reg[1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      det_reg        <= 6'd0;
      os_err         <= 1'b0;
      skp_len        <= 3'd0;
      ts_link_num    <= 8'd0;
      ts_lane_num    <= 8'd0;
      ts_n_fts       <= 8'd0;
      ts_rate        <= 8'd0;
      ts_ctrl        <= 8'd0;
      ts_link_pad    <= 1'b0;
      ts_lane_pad    <= 1'b0;
      ts_consec      <= 8'd0;
      prev_type_reg  <= 8'd0;
      prev_valid_reg <= 1'b0;
    end else begin
      det_reg <= det_next;
      os_err  <= err_next;
      if (det_next[2]) skp_len <= skp_len_val;
      if (ts_done) begin
        ts_link_num    <= buf_reg[0];
        ts_lane_num    <= buf_reg[1];
        ts_n_fts       <= buf_reg[2];
        ts_rate        <= buf_reg[3];
        ts_ctrl        <= buf_reg[4];
        ts_link_pad    <= pad_reg[0];
        ts_lane_pad    <= pad_reg[1];
        prev_type_reg  <= type_reg;
        prev_valid_reg <= 1'b1;
      end
      if (cnt_clr) ts_consec <= 8'd0;
      else if (ts_done) ts_consec <= !ts_same ? 8'd1 : (ts_consec == 8'hFF ? 8'hFF : ts_consec + 8'd1);
    end
  end

  logic [CNT_W-1:0] cnt_val [6];
  for (genvar gi = 0; gi < 6; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk) begin
      if (rst || cnt_clr) cnt_q <= '0;
      else if (det_next[gi] && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end
    assign cnt_val[gi] = cnt_q;
  end

  assign ts1_det   = det_reg[0];
  assign ts2_det   = det_reg[1];
  assign skp_det   = det_reg[2];
  assign fts_det   = det_reg[3];
  assign eios_det  = det_reg[4];
  assign eieos_det = det_reg[5];
  assign ts1_cnt   = cnt_val[0];
  assign ts2_cnt   = cnt_val[1];
  assign skp_cnt   = cnt_val[2];
  assign fts_cnt   = cnt_val[3];
  assign eios_cnt  = cnt_val[4];
  assign eieos_cnt = cnt_val[5];

endmodule
